// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS general-purpose register file.
// Default geometry and architecturally named register indices.
package regfile_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 32;
   localparam int unsigned DEFAULT_ADDR_W = 5;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_SP   = 29;
   localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/regfile_reg_word.sv
// One register word: WIDTH flip-flops with synchronous reset and load enable.
module reg_word #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   always_comb begin
      word_d = word_q;
      if (reset) begin
         word_d = '0;
      end else if (en) begin
         word_d = d;
      end
   end

   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   assign q = word_q;

endmodule

// File: rtl/regfile.sv
// MIPS register file: 32x32, two combinational read ports, one clocked write port.
// Register 0 has no storage and always reads zero.
module regfile
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata1,
   output logic [WIDTH-1:0]  rdata2
);

   logic [DEPTH-1:1]            wen;
   logic [DEPTH-1:0][WIDTH-1:0] words;
   logic [WIDTH-1:0]            stored1;
   logic [WIDTH-1:0]            stored2;
   logic                        fwd1;
   logic                        fwd2;

   // Reset blocks the write so a same-edge write cannot survive the clear.
   always_comb begin
      wen = '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         wen[i] = we && !reset && (waddr == ADDR_W'(i));
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (i == REG_ZERO) begin : g_zero
         assign words[i] = '0;
      end else begin : g_store
         reg_word #(
            .WIDTH (WIDTH)
         ) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (wen[i]),
            .d     (wdata),
            .q     (words[i])
         );
      end
   end

   assign stored1 = words[raddr1];
   assign stored2 = words[raddr2];

   assign fwd1 = (BYPASS != 0) && !reset && we && (waddr == raddr1);
   assign fwd2 = (BYPASS != 0) && !reset && we && (waddr == raddr2);

   always_comb begin
      rdata1 = stored1;
      if (raddr1 == ADDR_W'(REG_ZERO)) begin
         rdata1 = '0;
      end else if (fwd1) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = stored2;
      if (raddr2 == ADDR_W'(REG_ZERO)) begin
         rdata2 = '0;
      end else if (fwd2) begin
         rdata2 = wdata;
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: one instance with forwarding and one without, driven in lockstep
// and compared against an array model plus directed constants.
module tb_regfile;
   import regfile_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned D  = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          we;
   logic [AW-1:0] waddr;
   logic [W-1:0]  wdata;
   logic [AW-1:0] raddr1;
   logic [AW-1:0] raddr2;
   logic [W-1:0]  b_rd1, b_rd2, n_rd1, n_rd2;

   logic [W-1:0]  model [D];
   int            checks   = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   regfile #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .BYPASS(1)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (b_rd1),
      .rdata2 (b_rd2)
   );

   regfile #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .BYPASS(0)) dut_n (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr1 (raddr1),
      .raddr2 (raddr2),
      .rdata1 (n_rd1),
      .rdata2 (n_rd2)
   );

   function automatic logic [W-1:0] expect_rd(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && !reset && we && waddr == a) return wdata;
      return model[a];
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      #1;
      check({tag, ".byp.rd1"}, b_rd1, expect_rd(raddr1, 1'b1));
      check({tag, ".byp.rd2"}, b_rd2, expect_rd(raddr2, 1'b1));
      check({tag, ".nob.rd1"}, n_rd1, expect_rd(raddr1, 1'b0));
      check({tag, ".nob.rd2"}, n_rd2, expect_rd(raddr2, 1'b0));
   endtask

   // Advance one edge, applying the register-file rules to the model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < D; i++) model[i] = '0;
      end else if (we && waddr != 0) begin
         model[waddr] = wdata;
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      for (int i = 0; i < D; i++) model[i] = '0;
      @(negedge clk);
      tick();
      reset = 1'b0;
      check_model("post_reset");

      // Reset clear
      we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0; raddr1 = 5; #1;
      check("r5_written", b_rd1, 32'hDEADBEEF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int a = 0; a < D; a++) begin
         raddr1 = AW'(a); raddr2 = AW'(a); #1;
         check("reset_clear.b", b_rd1, '0);
         check("reset_clear.n", n_rd2, '0);
      end

      // Zero register
      we = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; raddr2 = 0; #1;
      check("zero_pre.b", b_rd1, '0);
      check("zero_pre.n", n_rd1, '0);
      tick();
      we = 1'b0; #1;
      check("zero_post.b", b_rd1, '0);
      check("zero_post.n", n_rd2, '0);

      // Write and read back every register
      for (int i = 1; i < D; i++) begin
         we = 1'b1; waddr = AW'(i); wdata = W'(i) * 32'h01010101;
         tick();
      end
      we = 1'b0;
      for (int i = 1; i < D; i++) begin
         raddr1 = AW'(i); raddr2 = AW'(D - i); #1;
         check("all.rd1.b", b_rd1, W'(i) * 32'h01010101);
         check("all.rd2.n", n_rd2, W'(D - i) * 32'h01010101);
      end

      // Forwarding
      we = 1'b1; waddr = 7; wdata = 32'h11111111;
      tick();
      waddr = 7; wdata = 32'h22222222; raddr1 = 7; raddr2 = 8; #1;
      check("byp.fwd", b_rd1, 32'h22222222);
      check("byp.other", b_rd2, 32'h08080808);
      check("nobyp.pre", n_rd1, 32'h11111111);
      check("nobyp.other", n_rd2, 32'h08080808);
      tick();
      we = 1'b0; #1;
      check("nobyp.post", n_rd1, 32'h22222222);
      check("byp.post", b_rd1, 32'h22222222);

      // Reset wins over a same-edge write, and suppresses forwarding
      reset = 1'b1; we = 1'b1; waddr = 3; wdata = 32'hCAFEF00D; raddr1 = 3; raddr2 = 3; #1;
      check("rst_vs_wr.nofwd", b_rd1, 32'h03030303);
      check("rst_vs_wr.nob", n_rd2, 32'h03030303);
      tick();
      reset = 1'b0; we = 1'b0; #1;
      check("rst_vs_wr.r3", b_rd1, '0);
      check("rst_vs_wr.r3n", n_rd1, '0);

      // Back-to-back writes to r31
      we = 1'b1; waddr = AW'(REG_RA); wdata = 32'hA; raddr1 = AW'(REG_RA); raddr2 = AW'(REG_SP);
      tick();
      wdata = 32'hB; #1;
      check("b2b.mid.nob", n_rd1, 32'hA);
      check("b2b.mid.byp", b_rd1, 32'hB);
      check("b2b.sp", b_rd2, '0);
      tick();
      we = 1'b0; #1;
      check("b2b.end.nob", n_rd1, 32'hB);
      check("b2b.end.byp", b_rd1, 32'hB);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset  = ($urandom_range(0, 24) == 0);
         we     = 1'($urandom_range(0, 1));
         waddr  = AW'($urandom_range(0, D - 1));
         wdata  = $urandom;
         raddr1 = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, D - 1));
         raddr2 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
         check_model("rand");
         tick();
      end
      reset = 1'b0; we = 1'b0;
      for (int a = 0; a < D; a++) begin
         raddr1 = AW'(a); raddr2 = AW'(a);
         check_model("final");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

MIPS general-purpose register file: 32 registers × 32 bits, two combinational read ports and one clocked write port. It consumes the single-bit flip-flop storage primitive, grouped into enabled words. It sits between instruction decode (read ports, rs/rt) and write-back (write port, rd/rt). Register 0 is hardwired to zero per the MIPS ISA.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; must equal 2**ADDR_W
- ADDR_W, 5, register address width
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return stored value only
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears every register on the rising edge where it is sampled high
- we  input  1  write enable
- waddr  input  ADDR_W  write register index
- wdata  input  WIDTH  write data
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  WIDTH  read port 1 data, combinational
- rdata2  output  WIDTH  read port 2 data, combinational

## Operation
- Write: on rising clk with reset=0, we=1, waddr≠0 → reg[waddr] ← wdata. All other registers hold.
- Writes to waddr=0 are discarded; reg[0] reads 0 at all times.
- Reset: on rising clk with reset=1 → all registers ← 0. Reset overrides we in the same cycle, so the write is lost.
- Read: rdataN = 0 if raddrN=0. Otherwise, with BYPASS=1, reset=0, we=1 and waddr=raddrN, rdataN = wdata. Otherwise rdataN = reg[raddrN].
- Both read ports are independent; equal raddr1/raddr2 return identical data.
- While reset=1, bypass is suppressed and reads return stored contents.
- No X propagation: all registers have defined values after the first reset edge.

## Timing
- Write latency: 1 cycle. Data is visible via storage from the cycle after the write edge.
- With BYPASS=1, data is also visible combinationally in the write cycle.
- Read latency: 0 cycles (combinational from raddr, storage, and bypass inputs).
- Reset latency: 1 edge. Outputs read 0 for every address from the edge where reset is sampled high until the next write.
- Reset deasserted mid-sequence: the first write is accepted on the first edge where reset=0.
- Back-to-back writes to the same address: last edge wins. A read in between shows the earlier value; with BYPASS=1 it shows the in-flight wdata.
- Simultaneous write to X and read of X and Y: port reading X follows the bypass rule; port reading Y returns stored data.

## Structure
- Shared package/header holds: REG_ZERO index (0), default WIDTH/ADDR_W, and MIPS register index constants (sp=29, ra=31).
- Sub-module reg_word:
  - WIDTH flops with synchronous reset and enable, built on the team's flip-flop primitive.
  - regfile instantiates DEPTH-1 of them via generate (indices 1..DEPTH-1); index 0 has no storage.
- Write decode: one-hot enable per word from we, waddr, and ~reset.
- Read muxes: two DEPTH:1 muxes followed by the bypass/zero override.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then reset=1 for one edge.
  - Required: rdata1 (raddr1=5) = 0x00000000; all 32 addresses read 0.
- Zero register:
  - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF, then read raddr1=0.
  - Required: 0x00000000, both before and after the edge.
- Write/read all registers:
  - Stimulus: write reg[i] = i×0x01010101 for i=1..31, then read each on both ports.
  - Required: exact values; no aliasing between addresses.
- Bypass:
  - Stimulus: r7 holds 0x11111111; in the same cycle drive we=1, waddr=7, wdata=0x22222222, raddr1=7, raddr2=8.
  - Required with BYPASS=1: rdata1=0x22222222 before the edge; rdata2 = stored r8.
  - Required with BYPASS=0: rdata1=0x11111111 before the edge, 0x22222222 after.
- Reset vs write:
  - Stimulus: reset=1 and we=1, waddr=3, wdata=0xCAFEF00D on the same edge.
  - Required: r3 = 0 afterwards; rdata shows no bypass while reset=1.
- Back-to-back:
  - Stimulus: write r31=0xA on edge n, r31=0xB on edge n+1.
  - Required: reads show 0xA in cycle n+1 and 0xB from cycle n+2.
